// File: rtl/rob_commit_pkg.sv
// Shared ROB configuration, entry layout and nick helpers.
// Nick = entry index + 1; nick 0 means "not renamed".
package rob_commit_pkg;

  localparam int DEPTH  = 16;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int NICK_W = 5;
  localparam int NAME_W = 5;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [NICK_W-1:0] NICK_NONE = '0;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [NICK_W-1:0] nick_t;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [NAME_W-1:0] rd_regnm;
    logic [DATA_W-1:0] dt;
    logic [ADDR_W-1:0] pc;
    logic              pd;
    logic              is_store;
    logic              is_branch;
    logic              jump;
    logic [ADDR_W-1:0] target;
  } rob_entry_t;

  function automatic nick_t idx2nick(idx_t i);
    return nick_t'(i) + nick_t'(1);
  endfunction

endpackage

// File: rtl/rob_commit_ptr_ctrl.sv
// ROB head/tail/occupancy tracking with mod-DEPTH wrap.
// Flush empties the buffer; rdy low holds everything.
module rob_ptr_ctrl
  import rob_commit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic push,
  input  logic pop,
  input  logic flush,
  output idx_t head,
  output idx_t tail,
  output logic full
);

  logic [CNT_W-1:0] count;

  assign full = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (pop)
          head <= head + idx_t'(1);
        if (push)
          tail <= tail + idx_t'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: nick allocation, CDB capture, in-order commit,
// store release and mispredict flush/redirect.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iDP_en,
  input  logic [NAME_W-1:0] iDP_rd_regnm,
  input  logic [ADDR_W-1:0] iDP_pc,
  input  logic              iDP_pd,
  input  logic              iDP_is_store,
  input  logic              iDP_is_branch,
  output logic [NICK_W-1:0] oDP_nick,
  output logic              oDP_full,
  output logic              oRF_nick_en,
  output logic [NAME_W-1:0] oRF_nick_regnm,
  output logic [NICK_W-1:0] oRF_nick,
  input  logic              iCDB_en,
  input  logic [NICK_W-1:0] iCDB_nick,
  input  logic [DATA_W-1:0] iCDB_dt,
  input  logic              iCDB_jump,
  input  logic [ADDR_W-1:0] iCDB_target,
  output logic              oRF_en,
  output logic [NAME_W-1:0] oRF_rd_regnm,
  output logic [DATA_W-1:0] oRF_rd_dt,
  output logic [NICK_W-1:0] oRF_rd_nick,
  output logic              oLSB_st_en,
  output logic [NICK_W-1:0] oLSB_st_nick,
  output logic              oClr,
  output logic              oPC_en,
  output logic [ADDR_W-1:0] oPC_target
);

  rob_entry_t rob [DEPTH];
  rob_entry_t head_e;
  idx_t       head, tail, cdb_idx;
  logic       full, dp_acc, cm, mp, cdb_hit;

  rob_ptr_ctrl u_ptr (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .push  (dp_acc),
    .pop   (cm),
    .flush (mp),
    .head  (head),
    .tail  (tail),
    .full  (full)
  );

  assign head_e  = rob[head];
  assign dp_acc  = rdy && iDP_en && !full && !oClr;
  assign cm      = rdy && head_e.busy && head_e.ready;
  assign mp      = cm && head_e.is_branch
                   && (head_e.jump != head_e.pd);
  assign cdb_idx = idx_t'(iCDB_nick - nick_t'(1));
  // Out-of-range nicks must not alias onto a live entry.
  assign cdb_hit = rdy && iCDB_en && !oClr
                   && iCDB_nick != NICK_NONE
                   && iCDB_nick <= nick_t'(DEPTH)
                   && rob[cdb_idx].busy;

  assign oDP_nick       = idx2nick(tail);
  assign oDP_full       = full;
  assign oRF_nick_en    = dp_acc && !iDP_is_store
                          && iDP_rd_regnm != '0;
  assign oRF_nick_regnm = oRF_nick_en ? iDP_rd_regnm : '0;
  assign oRF_nick       = oRF_nick_en ? idx2nick(tail) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        rob[i] <= '0;
    end else if (rdy) begin
      if (mp) begin
        for (int i = 0; i < DEPTH; i++)
          rob[i].busy <= 1'b0;
      end else begin
        if (cm)
          rob[head].busy <= 1'b0;
        if (dp_acc)
          rob[tail] <= '{
            busy:      1'b1,
            ready:     iDP_is_store,
            rd_regnm:  iDP_rd_regnm,
            dt:        '0,
            pc:        iDP_pc,
            pd:        iDP_pd,
            is_store:  iDP_is_store,
            is_branch: iDP_is_branch,
            jump:      1'b0,
            target:    '0
          };
        if (cdb_hit) begin
          rob[cdb_idx].ready  <= 1'b1;
          rob[cdb_idx].dt     <= iCDB_dt;
          rob[cdb_idx].jump   <= iCDB_jump;
          rob[cdb_idx].target <= iCDB_target;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !rdy) begin
      oRF_en       <= 1'b0;
      oRF_rd_regnm <= '0;
      oRF_rd_dt    <= '0;
      oRF_rd_nick  <= '0;
      oLSB_st_en   <= 1'b0;
      oLSB_st_nick <= '0;
      oClr         <= 1'b0;
      oPC_en       <= 1'b0;
      oPC_target   <= '0;
    end else begin
      oRF_en       <= 1'b0;
      oRF_rd_regnm <= '0;
      oRF_rd_dt    <= '0;
      oRF_rd_nick  <= '0;
      oLSB_st_en   <= 1'b0;
      oLSB_st_nick <= '0;
      oClr         <= mp;
      oPC_en       <= mp;
      oPC_target   <= '0;
      if (cm && head_e.is_store) begin
        oLSB_st_en   <= 1'b1;
        oLSB_st_nick <= idx2nick(head);
      end
      if (cm && !head_e.is_store && head_e.rd_regnm != '0) begin
        oRF_en       <= 1'b1;
        oRF_rd_regnm <= head_e.rd_regnm;
        oRF_rd_dt    <= head_e.dt;
        oRF_rd_nick  <= idx2nick(head);
      end
      if (mp)
        oPC_target <= head_e.jump ? head_e.target
                                  : head_e.pc + ADDR_W'(4);
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: rename, ordering, full/wrap,
// mispredict flush, stores, rdy freeze and reset override.
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic              clk = 1'b0;
  logic              rst, rdy;
  logic              iDP_en, iDP_pd, iDP_is_store, iDP_is_branch;
  logic [NAME_W-1:0] iDP_rd_regnm;
  logic [ADDR_W-1:0] iDP_pc;
  logic [NICK_W-1:0] oDP_nick, oRF_nick, oRF_rd_nick, oLSB_st_nick;
  logic              oDP_full, oRF_nick_en, oRF_en, oLSB_st_en;
  logic [NAME_W-1:0] oRF_nick_regnm, oRF_rd_regnm;
  logic              iCDB_en, iCDB_jump;
  logic [NICK_W-1:0] iCDB_nick;
  logic [DATA_W-1:0] iCDB_dt, oRF_rd_dt;
  logic [ADDR_W-1:0] iCDB_target, oPC_target;
  logic              oClr, oPC_en;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iDP_en(iDP_en), .iDP_rd_regnm(iDP_rd_regnm),
    .iDP_pc(iDP_pc), .iDP_pd(iDP_pd),
    .iDP_is_store(iDP_is_store), .iDP_is_branch(iDP_is_branch),
    .oDP_nick(oDP_nick), .oDP_full(oDP_full),
    .oRF_nick_en(oRF_nick_en), .oRF_nick_regnm(oRF_nick_regnm),
    .oRF_nick(oRF_nick),
    .iCDB_en(iCDB_en), .iCDB_nick(iCDB_nick), .iCDB_dt(iCDB_dt),
    .iCDB_jump(iCDB_jump), .iCDB_target(iCDB_target),
    .oRF_en(oRF_en), .oRF_rd_regnm(oRF_rd_regnm),
    .oRF_rd_dt(oRF_rd_dt), .oRF_rd_nick(oRF_rd_nick),
    .oLSB_st_en(oLSB_st_en), .oLSB_st_nick(oLSB_st_nick),
    .oClr(oClr), .oPC_en(oPC_en), .oPC_target(oPC_target)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iDP_en = 1'b0; iDP_rd_regnm = '0; iDP_pc = '0; iDP_pd = 1'b0;
    iDP_is_store = 1'b0; iDP_is_branch = 1'b0;
    iCDB_en = 1'b0; iCDB_nick = '0; iCDB_dt = '0;
    iCDB_jump = 1'b0; iCDB_target = '0;
  endtask

  task automatic dp(input logic [NAME_W-1:0] rd,
                    input logic [ADDR_W-1:0] pc, input logic pd,
                    input logic st, input logic br);
    iDP_en = 1'b1; iDP_rd_regnm = rd; iDP_pc = pc; iDP_pd = pd;
    iDP_is_store = st; iDP_is_branch = br;
  endtask

  task automatic cdb(input logic [NICK_W-1:0] n,
                     input logic [DATA_W-1:0] d, input logic j,
                     input logic [ADDR_W-1:0] t);
    iCDB_en = 1'b1; iCDB_nick = n; iCDB_dt = d;
    iCDB_jump = j; iCDB_target = t;
  endtask

  task automatic do_reset();
    idle();
    rdy = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_commit(input string tag, input logic en,
                            input logic [NAME_W-1:0] rd,
                            input logic [DATA_W-1:0] d,
                            input logic [NICK_W-1:0] n);
    chk({tag, "_en"}, oRF_en, en);
    if (en) begin
      chk({tag, "_rd"}, oRF_rd_regnm, rd);
      chk({tag, "_dt"}, oRF_rd_dt, d);
      chk({tag, "_nick"}, oRF_rd_nick, n);
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_rf_en", oRF_en, 0);
    chk("rst_lsb_en", oLSB_st_en, 0);
    chk("rst_clr", oClr, 0);
    chk("rst_pc_en", oPC_en, 0);
    chk("rst_pc_tgt", oPC_target, 0);
    chk("rst_full", oDP_full, 0);
    chk("rst_nick", oDP_nick, 1);

    // 1: three renames
    for (int i = 0; i < 3; i++) begin
      dp(NAME_W'(5 + i), 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      #1;
      chk("ren_nick", oDP_nick, 64'(i + 1));
      chk("ren_en", oRF_nick_en, 1);
      chk("ren_regnm", oRF_nick_regnm, 64'(5 + i));
      chk("ren_rfnick", oRF_nick, 64'(i + 1));
      tick();
    end
    idle();

    // 2: out-of-order results, in-order commit
    cdb(5'd3, 32'h30, 1'b0, 32'h0);
    tick();
    chk("ooo_no_commit0", oRF_en, 0);
    cdb(5'd1, 32'h10, 1'b0, 32'h0);
    tick();
    chk("ooo_no_commit1", oRF_en, 0);
    cdb(5'd2, 32'h20, 1'b0, 32'h0);
    tick();
    chk_commit("cm1", 1'b1, 5'd5, 32'h10, 5'd1);
    idle();
    tick();
    chk_commit("cm2", 1'b1, 5'd6, 32'h20, 5'd2);
    tick();
    chk_commit("cm3", 1'b1, 5'd7, 32'h30, 5'd3);
    tick();
    chk_commit("cm_idle", 1'b0, 5'd0, 32'h0, 5'd0);

    // 3: fill, refuse, commit one, wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      dp(5'd8, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("fill_nick", oDP_nick, 64'(i + 1));
      chk("fill_full", oDP_full, 0);
      tick();
    end
    dp(5'd9, 32'h0, 1'b0, 1'b0, 1'b0);
    cdb(5'd1, 32'h81, 1'b0, 32'h0);
    #1;
    chk("full_set", oDP_full, 1);
    chk("full_refuse", oRF_nick_en, 0);
    tick();
    iCDB_en = 1'b0;
    #1;
    chk("full_same_cyc", oDP_full, 1);
    chk("full_same_ren", oRF_nick_en, 0);
    tick();
    chk_commit("full_cm", 1'b1, 5'd8, 32'h81, 5'd1);
    chk("full_clear", oDP_full, 0);
    chk("wrap_nick", oDP_nick, 1);
    chk("wrap_ren", oRF_nick_en, 1);
    chk("wrap_rfnick", oRF_nick, 1);
    tick();
    idle();
    #1;
    chk("refull", oDP_full, 1);

    // 4: mispredict taken, then not-taken
    do_reset();
    dp(5'd1, 32'h100, 1'b0, 1'b0, 1'b1);
    tick();
    dp(5'd2, 32'h104, 1'b0, 1'b0, 1'b0);
    tick();
    dp(5'd3, 32'h108, 1'b0, 1'b0, 1'b0);
    cdb(5'd1, 32'h104, 1'b1, 32'h1000);
    tick();
    idle();
    tick();
    chk("mp_clr", oClr, 1);
    chk("mp_pc_en", oPC_en, 1);
    chk("mp_tgt", oPC_target, 32'h1000);
    chk_commit("mp_link", 1'b1, 5'd1, 32'h104, 5'd1);
    dp(5'd4, 32'h300, 1'b0, 1'b0, 1'b0);
    cdb(5'd2, 32'h55, 1'b0, 32'h0);
    #1;
    chk("mp_drop_dp", oRF_nick_en, 0);
    chk("mp_nick_rst", oDP_nick, 1);
    tick();
    iCDB_en = 1'b0;
    chk("mp_clr_pulse", oClr, 0);
    chk("mp_pc_pulse", oPC_en, 0);
    chk("mp_rf_pulse", oRF_en, 0);
    chk("mp_new_nick", oDP_nick, 1);
    chk("mp_new_ren", oRF_nick_en, 1);
    tick();
    dp(5'd0, 32'h200, 1'b1, 1'b0, 1'b1);
    #1;
    chk("nt_nick", oDP_nick, 2);
    tick();
    idle();
    cdb(5'd1, 32'h7, 1'b0, 32'h0);
    tick();
    cdb(5'd2, 32'h0, 1'b0, 32'h0);
    tick();
    chk_commit("nt_pre", 1'b1, 5'd4, 32'h7, 5'd1);
    chk("nt_pre_clr", oClr, 0);
    idle();
    tick();
    chk("nt_clr", oClr, 1);
    chk("nt_tgt", oPC_target, 32'h204);
    chk("nt_rf", oRF_en, 0);

    // 5: store and rd=0
    do_reset();
    dp(5'd1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    dp(5'd3, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("st_nick", oDP_nick, 2);
    chk("st_noren", oRF_nick_en, 0);
    tick();
    dp(5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("r0_nick", oDP_nick, 3);
    chk("r0_noren", oRF_nick_en, 0);
    tick();
    idle();
    cdb(5'd1, 32'h11, 1'b0, 32'h0);
    tick();
    cdb(5'd3, 32'h33, 1'b0, 32'h0);
    tick();
    chk_commit("st_pre", 1'b1, 5'd1, 32'h11, 5'd1);
    chk("st_pre_lsb", oLSB_st_en, 0);
    idle();
    tick();
    chk("st_lsb_en", oLSB_st_en, 1);
    chk("st_lsb_nick", oLSB_st_nick, 2);
    chk("st_rf", oRF_en, 0);
    tick();
    chk("r0_rf", oRF_en, 0);
    chk("r0_lsb", oLSB_st_en, 0);

    // 6: rdy freeze, then reset over a pending mispredict
    do_reset();
    dp(5'd9, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    cdb(5'd1, 32'h99, 1'b0, 32'h0);
    tick();
    idle();
    rdy = 1'b0;
    dp(5'd2, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("frz_ren", oRF_nick_en, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frz_rf", oRF_en, 0);
    end
    idle();
    rdy = 1'b1;
    tick();
    chk_commit("frz_cm", 1'b1, 5'd9, 32'h99, 5'd1);
    dp(5'd4, 32'h400, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rr_nick", oDP_nick, 2);
    tick();
    idle();
    cdb(5'd2, 32'h404, 1'b1, 32'h2000);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rr_clr", oClr, 0);
    chk("rr_pc_en", oPC_en, 0);
    chk("rr_rf", oRF_en, 0);
    chk("rr_nick0", oDP_nick, 1);
    chk("rr_full", oDP_full, 0);
    tick();
    chk("rr_clr2", oClr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
